ip_encode: RTL

- IPv4 header generator and payload framer on the transmit path, sitting between the UDP transmit logic and the MAC transmit byte stream.
- On a start request it latches the source address, destination address and payload length, then computes the header checksum.
- It then emits a 20-byte IPv4 header, no options, one byte per accepted beat, followed by the payload passed through from upstream.
- It is the transmit counterpart of the IPv4 receive decoder.

---
 rtl/ip_pkg.sv | 31 +++
 rtl/ip_checksum.sv | 33 +++
 rtl/ip_encode.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ip_pkg.sv
// ---------------------------------------------------------------------------
// ip_pkg
// Shared IPv4 definitions for the transmit encoder and the receive decoder:
// header constants, the encoder state encoding and the ones'-complement
// adder used for the IPv4 header checksum.
// ---------------------------------------------------------------------------
package ip_pkg;

  localparam int          IP_HDR_BYTES   = 20;
  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
  localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [15:0] IP_MAX_PAYLOAD = 16'd65515;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CSUM    = 2'd1,
    HDR     = 2'd2,
    PAYLOAD = 2'd3
  } ip_state_e;

  // 16-bit ones'-complement add: the carry out of bit 15 is folded back
  // into bit 0. A single fold is enough because a + b <= 17'h1FFFE.
  function automatic logic [15:0] ip_ones_add(input logic [15:0] a,
                                              input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ip_checksum.sv
// ---------------------------------------------------------------------------
// ip_checksum
// Sequential ones'-complement accumulator for the IPv4 header checksum.
//   clk      : system clock
//   clr      : zero the accumulator (takes priority over word_vld)
//   word_vld : add word into the accumulator this cycle
//   word     : 16-bit header word
//   sum      : running ones'-complement sum (not inverted)
// ---------------------------------------------------------------------------
module ip_checksum
  import ip_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        word_vld,
  input  logic [15:0] word,
  output logic [15:0] sum
);

  logic [15:0] acc_p0;

  // Stage 0: accumulate one word per valid cycle
  always_ff @(posedge clk) begin
    if (clr) begin
      acc_p0 <= 16'h0000;
    end else if (word_vld) begin
      acc_p0 <= ip_ones_add(acc_p0, word);
    end
  end

  assign sum = acc_p0;

endmodule

// File: rtl/ip_encode.sv
// ---------------------------------------------------------------------------
// ip_encode
// IPv4 transmit framer: on start, latches addresses and payload length,
// computes the header checksum over nine words, emits the 20-byte header
// (no options) and then passes the payload through from upstream.
//   clk, rst          : clock, synchronous active-high reset
//   start             : packet request, only honoured in IDLE
//   sa, da            : source / destination address (latched on accept)
//   payload_len       : payload byte count (latched on accept)
//   busy              : packet in progress (including the done cycle)
//   in_data/valid/ready : upstream payload byte stream
//   dout/out_valid/out_ready/out_last : downstream byte stream
//   done              : one-cycle pulse after the final byte transfers
//   err               : one-cycle pulse when start carries an oversize length
// ---------------------------------------------------------------------------
module ip_encode
  import ip_pkg::*;
#(
  parameter logic [7:0]  TTL      = 8'd64,
  parameter logic [7:0]  PROTOCOL = IP_PROTO_UDP,
  parameter logic [15:0] ID_INIT  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] sa,
  input  logic [31:0] da,
  input  logic [15:0] payload_len,
  output logic        busy,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        done,
  output logic        err
);

  localparam logic [4:0] LAST_HDR_IDX  = 5'(IP_HDR_BYTES - 1);
  localparam logic [3:0] LAST_WORD_IDX = 4'd8;

  ip_state_e   state_q, state_d;

  logic [31:0] sa_q, da_q;
  logic [15:0] len_q, total_q;
  logic [15:0] id_q;
  logic [3:0]  word_idx_q;
  logic [4:0]  byte_idx_q;
  logic [15:0] rem_q;
  logic        done_q, err_q;

  logic        accept, reject, finish;
  logic        hdr_xfer, pay_xfer;
  logic        csum_clr, csum_vld;
  logic [15:0] csum_word, csum_sum, checksum;
  logic [7:0]  hdr_byte;

  assign checksum = ~csum_sum;

  // Header words fed to the checksum, checksum field itself excluded.
  always_comb begin
    csum_word = 16'h0000;
    case (word_idx_q)
      4'd0:    csum_word = {IPV4_VER_IHL, 8'h00};
      4'd1:    csum_word = total_q;
      4'd2:    csum_word = id_q;
      4'd3:    csum_word = IP_FLAGS_DF;
      4'd4:    csum_word = {TTL, PROTOCOL};
      4'd5:    csum_word = sa_q[31:16];
      4'd6:    csum_word = sa_q[15:0];
      4'd7:    csum_word = da_q[31:16];
      4'd8:    csum_word = da_q[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  // Header bytes in network (big-endian) order.
  always_comb begin
    hdr_byte = 8'h00;
    case (byte_idx_q)
      5'd0:    hdr_byte = IPV4_VER_IHL;
      5'd1:    hdr_byte = 8'h00;
      5'd2:    hdr_byte = total_q[15:8];
      5'd3:    hdr_byte = total_q[7:0];
      5'd4:    hdr_byte = id_q[15:8];
      5'd5:    hdr_byte = id_q[7:0];
      5'd6:    hdr_byte = IP_FLAGS_DF[15:8];
      5'd7:    hdr_byte = IP_FLAGS_DF[7:0];
      5'd8:    hdr_byte = TTL;
      5'd9:    hdr_byte = PROTOCOL;
      5'd10:   hdr_byte = checksum[15:8];
      5'd11:   hdr_byte = checksum[7:0];
      5'd12:   hdr_byte = sa_q[31:24];
      5'd13:   hdr_byte = sa_q[23:16];
      5'd14:   hdr_byte = sa_q[15:8];
      5'd15:   hdr_byte = sa_q[7:0];
      5'd16:   hdr_byte = da_q[31:24];
      5'd17:   hdr_byte = da_q[23:16];
      5'd18:   hdr_byte = da_q[15:8];
      5'd19:   hdr_byte = da_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  // Next state and stream outputs. In PAYLOAD the handshake is a pure
  // combinational pass-through so no bubble is inserted.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    reject    = 1'b0;
    finish    = 1'b0;
    hdr_xfer  = 1'b0;
    pay_xfer  = 1'b0;
    csum_clr  = 1'b0;
    csum_vld  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    dout      = 8'h00;
    case (state_q)
      IDLE: begin
        csum_clr = 1'b1;
        if (start) begin
          if (payload_len <= IP_MAX_PAYLOAD) begin
            accept  = 1'b1;
            state_d = CSUM;
          end else begin
            reject = 1'b1;
          end
        end
      end
      CSUM: begin
        csum_vld = 1'b1;
        if (word_idx_q == LAST_WORD_IDX) begin
          state_d = HDR;
        end
      end
      HDR: begin
        out_valid = 1'b1;
        dout      = hdr_byte;
        out_last  = (byte_idx_q == LAST_HDR_IDX) && (len_q == 16'd0);
        hdr_xfer  = out_ready;
        if (out_ready && (byte_idx_q == LAST_HDR_IDX)) begin
          if (len_q == 16'd0) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        dout      = in_data;
        out_valid = in_valid;
        in_ready  = out_ready;
        out_last  = (rem_q == 16'd1);
        pay_xfer  = in_valid && out_ready;
        if (pay_xfer && (rem_q == 16'd1)) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      word_idx_q <= 4'd0;
      byte_idx_q <= 5'd0;
      rem_q      <= 16'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      id_q       <= ID_INIT;
    end else begin
      state_q <= state_d;
      done_q  <= finish;
      err_q   <= reject;
      if (finish) begin
        id_q <= id_q + 16'd1;
      end
      if (accept) begin
        word_idx_q <= 4'd0;
      end else if (state_q == CSUM) begin
        word_idx_q <= word_idx_q + 4'd1;
      end
      if (accept) begin
        byte_idx_q <= 5'd0;
      end else if (hdr_xfer) begin
        byte_idx_q <= byte_idx_q + 5'd1;
      end
      if (hdr_xfer && (byte_idx_q == LAST_HDR_IDX)) begin
        rem_q <= len_q;
      end else if (pay_xfer) begin
        rem_q <= rem_q - 16'd1;
      end
    end
  end

  // Packet fields, captured on an accepted start
  always_ff @(posedge clk) begin
    if (accept) begin
      sa_q    <= sa;
      da_q    <= da;
      len_q   <= payload_len;
      total_q <= payload_len + 16'(IP_HDR_BYTES);
    end
  end

  ip_checksum u_checksum (
    .clk      (clk),
    .clr      (csum_clr),
    .word_vld (csum_vld),
    .word     (csum_word),
    .sum      (csum_sum)
  );

  // done cycle is reported busy so the window covers the whole packet.
  assign busy = (state_q != IDLE) || done_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
